siso_llr_calc: RTL and testbench

Parametrised, pipelined max-log-MAP LLR stage for the 8-state constituent SISO decoder. It consumes one trellis step per beat: alpha[0..7], beta[0..7] of the next step, and the two branch metrics g1/g2 from init_branch. It emits the a-posteriori LLR per information bit, and optionally the extrinsic value. It sits after alpha and beta_llr, replacing ad-hoc LLR logic with a block-framed, back-pressurable stream.

---
 rtl/siso_llr_calc_if.sv | 46 ++++
 rtl/siso_llr_calc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_siso_llr_calc.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/siso_llr_calc_if.sv
// ----------------------------------------------------------------------------
// siso_llr_calc_if
//   Stream interface of the max-log-MAP LLR stage.
//
//   Block framing : blklen, blklen_valid
//   Input stream  : in_valid / in_ready, alpha_in, beta_in, g1, g2, sys, apriori
//   Output stream : out_valid / out_ready, llr_out, ext_out, out_last
//   Status        : busy
//
//   master : the side that feeds steps and consumes LLRs (upstream/downstream)
//   slave  : the LLR stage itself
// ----------------------------------------------------------------------------
interface siso_llr_calc_if #(
    parameter int W     = 16,
    parameter int LLR_W = 16,
    parameter int BLK_W = 16
);
    logic [BLK_W-1:0] blklen;
    logic             blklen_valid;
    logic             in_valid;
    logic             in_ready;
    logic [8*W-1:0]   alpha_in;
    logic [8*W-1:0]   beta_in;
    logic [W-1:0]     g1;
    logic [W-1:0]     g2;
    logic [W-1:0]     sys;
    logic [W-1:0]     apriori;
    logic             out_valid;
    logic             out_ready;
    logic [LLR_W-1:0] llr_out;
    logic [LLR_W-1:0] ext_out;
    logic             out_last;
    logic             busy;

    modport master (
        output blklen, blklen_valid, in_valid, alpha_in, beta_in, g1, g2,
               sys, apriori, out_ready,
        input  in_ready, out_valid, llr_out, ext_out, out_last, busy
    );

    modport slave (
        input  blklen, blklen_valid, in_valid, alpha_in, beta_in, g1, g2,
               sys, apriori, out_ready,
        output in_ready, out_valid, llr_out, ext_out, out_last, busy
    );
endinterface

// File: rtl/siso_llr_calc.sv
// ----------------------------------------------------------------------------
// siso_llr_calc
//   Pipelined max-log-MAP LLR stage for the 8-state constituent SISO decoder.
//   One trellis step per beat: P/M branch sums, two 8->1 max trees, then
//   llr = maxM - maxP saturated to LLR_W. Block framed by blklen, fully
//   back-pressurable (the whole pipeline freezes while the output stalls).
//
//   Optional build macro: SISO_LLR_EXTRINSIC_EN
//     defined   : extra stage computes ext = llr - sys - apriori (latency 6)
//     undefined : ext_out = 0, sys/apriori ignored (latency 5)
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : siso_llr_calc_if.slave (framing, input stream, output stream, busy)
// ----------------------------------------------------------------------------
module siso_llr_calc #(
    parameter int W     = 16,
    parameter int LLR_W = 16,
    parameter int BLK_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    siso_llr_calc_if.slave bus
);
    localparam int SW = W + 2;   // branch-sum width (three W-bit terms)
    localparam int DW = W + 3;   // maxM - maxP width
`ifdef SISO_LLR_EXTRINSIC_EN
    localparam int NSTG = 6;
`else
    localparam int NSTG = 5;
`endif

    localparam logic signed [LLR_W-1:0] LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};
    localparam logic signed [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};

    // Trellis next-state for the u=1 and u=0 branches.
    function automatic int plus_ns(input int s);
        case (s)
            0: return 0;  1: return 4;  2: return 5;  3: return 1;
            4: return 2;  5: return 6;  6: return 7;  default: return 3;
        endcase
    endfunction

    function automatic int minus_ns(input int s);
        case (s)
            0: return 4;  1: return 0;  2: return 1;  3: return 5;
            4: return 6;  5: return 2;  6: return 3;  default: return 7;
        endcase
    endfunction

    // Ties keep the lower index; only the value leaves the tree anyway.
    function automatic logic signed [SW-1:0] smax(input logic signed [SW-1:0] a,
                                                  input logic signed [SW-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state_reg;
    logic [BLK_W-1:0] blklen_reg;
    logic [BLK_W-1:0] cnt_reg;
    logic [NSTG-1:0]  vld_reg;
    logic [NSTG-1:0]  last_reg;

    logic stall;
    logic pipe_en;
    logic in_ready;
    logic accept;
    logic is_last;
    logic last_fire;

    assign stall     = vld_reg[NSTG-1] && !bus.out_ready;
    assign pipe_en   = !stall;
    assign in_ready  = (state_reg == S_RUN) && !stall;
    assign accept    = bus.in_valid && in_ready;
    assign is_last   = (cnt_reg == (blklen_reg - BLK_W'(1)));
    assign last_fire = vld_reg[NSTG-1] && bus.out_ready && last_reg[NSTG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            blklen_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.blklen_valid && (bus.blklen != '0)) begin
                        blklen_reg <= bus.blklen;
                        cnt_reg    <= '0;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + BLK_W'(1);
                        if (is_last) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_fire) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational: branch sums per starting state
    // ------------------------------------------------------------------
    logic signed [SW-1:0] p_c [8];
    logic signed [SW-1:0] m_c [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_branch
        localparam int PN     = plus_ns(gi);
        localparam int MN     = minus_ns(gi);
        localparam bit USE_G1 = (gi == 0) || (gi == 1) || (gi == 6) || (gi == 7);

        logic signed [SW-1:0] a_x;
        logic signed [SW-1:0] b_p;
        logic signed [SW-1:0] b_m;
        logic signed [SW-1:0] g_x;

        assign a_x = SW'($signed(bus.alpha_in[gi*W +: W]));
        assign b_p = SW'($signed(bus.beta_in[PN*W +: W]));
        assign b_m = SW'($signed(bus.beta_in[MN*W +: W]));
        assign g_x = USE_G1 ? SW'($signed(bus.g1)) : SW'($signed(bus.g2));

        assign p_c[gi] = a_x + g_x + b_p;
        assign m_c[gi] = a_x - g_x + b_m;
    end

    // ------------------------------------------------------------------
    // Pipeline registers: stage 1 sums, stages 2-4 max trees, stage 5 LLR
    // ------------------------------------------------------------------
    logic signed [SW-1:0]    p1_reg [8];
    logic signed [SW-1:0]    m1_reg [8];
    logic signed [SW-1:0]    p2_reg [4];
    logic signed [SW-1:0]    m2_reg [4];
    logic signed [SW-1:0]    p3_reg [2];
    logic signed [SW-1:0]    m3_reg [2];
    logic signed [SW-1:0]    p4_reg;
    logic signed [SW-1:0]    m4_reg;
    logic signed [LLR_W-1:0] llr5_reg;

    logic signed [DW-1:0]    diff_c;
    logic signed [LLR_W-1:0] llr_c;

    assign diff_c = DW'(m4_reg) - DW'(p4_reg);

    if (DW <= LLR_W) begin : g_llr_wide
        assign llr_c = LLR_W'(diff_c);
    end else begin : g_llr_sat
        assign llr_c = (diff_c > DW'(LLR_MAX)) ? LLR_MAX :
                       (diff_c < DW'(LLR_MIN)) ? LLR_MIN :
                       diff_c[LLR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg  <= '0;
            last_reg <= '0;
            for (int i = 0; i < 8; i++) begin
                p1_reg[i] <= '0;
                m1_reg[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                p2_reg[i] <= '0;
                m2_reg[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                p3_reg[i] <= '0;
                m3_reg[i] <= '0;
            end
            p4_reg   <= '0;
            m4_reg   <= '0;
            llr5_reg <= '0;
        end else if (pipe_en) begin
            // accept can only be high when the pipe moves, so shifting it in
            // here never loses a step.
            vld_reg  <= {vld_reg[NSTG-2:0], accept};
            last_reg <= {last_reg[NSTG-2:0], accept && is_last};
            for (int i = 0; i < 8; i++) begin
                p1_reg[i] <= p_c[i];
                m1_reg[i] <= m_c[i];
            end
            for (int i = 0; i < 4; i++) begin
                p2_reg[i] <= smax(p1_reg[2*i], p1_reg[2*i+1]);
                m2_reg[i] <= smax(m1_reg[2*i], m1_reg[2*i+1]);
            end
            for (int i = 0; i < 2; i++) begin
                p3_reg[i] <= smax(p2_reg[2*i], p2_reg[2*i+1]);
                m3_reg[i] <= smax(m2_reg[2*i], m2_reg[2*i+1]);
            end
            p4_reg   <= smax(p3_reg[0], p3_reg[1]);
            m4_reg   <= smax(m3_reg[0], m3_reg[1]);
            llr5_reg <= llr_c;
        end
    end

`ifdef SISO_LLR_EXTRINSIC_EN
    // ------------------------------------------------------------------
    // Extrinsic stage: sys/apriori ride along stages 1-5 with their step
    // ------------------------------------------------------------------
    // Wide enough for either operand width plus two subtractions.
    localparam int XW = ((W > LLR_W) ? W : LLR_W) + 2;

    logic signed [W-1:0]     sys_reg [5];
    logic signed [W-1:0]     apr_reg [5];
    logic signed [LLR_W-1:0] llr6_reg;
    logic signed [LLR_W-1:0] ext6_reg;
    logic signed [XW-1:0]    ext_x;
    logic signed [LLR_W-1:0] ext_c;

    assign ext_x = XW'(llr5_reg) - XW'(sys_reg[4]) - XW'(apr_reg[4]);
    assign ext_c = (ext_x > XW'(LLR_MAX)) ? LLR_MAX :
                   (ext_x < XW'(LLR_MIN)) ? LLR_MIN :
                   ext_x[LLR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                sys_reg[i] <= '0;
                apr_reg[i] <= '0;
            end
            llr6_reg <= '0;
            ext6_reg <= '0;
        end else if (pipe_en) begin
            sys_reg[0] <= $signed(bus.sys);
            apr_reg[0] <= $signed(bus.apriori);
            for (int i = 1; i < 5; i++) begin
                sys_reg[i] <= sys_reg[i-1];
                apr_reg[i] <= apr_reg[i-1];
            end
            llr6_reg <= llr5_reg;
            ext6_reg <= ext_c;
        end
    end

    assign bus.llr_out = llr6_reg;
    assign bus.ext_out = ext6_reg;
`else
    logic unused_ext;
    assign unused_ext  = ^{bus.sys, bus.apriori};
    assign bus.llr_out = llr5_reg;
    assign bus.ext_out = '0;
`endif

    assign bus.out_valid = vld_reg[NSTG-1];
    assign bus.out_last  = last_reg[NSTG-1];
    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_reg != S_IDLE);
endmodule

// File: tb/tb_siso_llr_calc.sv
// ----------------------------------------------------------------------------
// tb_siso_llr_calc
//   Randomised and directed stimulus for siso_llr_calc (W=16, LLR_W=8) checked
//   against a trellis-level reference model: each accepted step is scored with
//   plain integer arithmetic over all 16 branches and queued with its expected
//   LLR / extrinsic / last flag; output beats pop the queue in order.
// ----------------------------------------------------------------------------
module tb_siso_llr_calc;
    localparam int W     = 16;
    localparam int LLR_W = 8;
    localparam int BLK_W = 16;
`ifdef SISO_LLR_EXTRINSIC_EN
    localparam int LAT    = 6;
    localparam bit EXT_EN = 1'b1;
`else
    localparam int LAT    = 5;
    localparam bit EXT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    siso_llr_calc_if #(.W(W), .LLR_W(LLR_W), .BLK_W(BLK_W)) bus ();

    siso_llr_calc #(.W(W), .LLR_W(LLR_W), .BLK_W(BLK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int llr;
        int ext;
        bit last;
        int cyc;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    int   plus_tab[8]  = '{0, 4, 5, 1, 2, 6, 7, 3};
    int   minus_tab[8] = '{4, 0, 1, 5, 6, 2, 3, 7};
    int   cur_a[8];
    int   cur_b[8];
    int   cur_g1, cur_g2, cur_sys, cur_apr, cur_tag;
    int   cur_n, acc_cnt, cyc, beat_no;
    bit   have_step, chk_lat;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int sat(input int v);
        int lim;
        lim = 1 << (LLR_W - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic int rnd(input int r);
        return int'($urandom_range(0, 2 * r)) - r;
    endfunction

    // max over all u=1 branches vs all u=0 branches of the current step
    task automatic model(output int llr, output int ext);
        int mp, mm, p, m, g;
        mp = -(1 << 30);
        mm = -(1 << 30);
        for (int s = 0; s < 8; s++) begin
            g = (s == 0 || s == 1 || s == 6 || s == 7) ? cur_g1 : cur_g2;
            p = cur_a[s] + g + cur_b[plus_tab[s]];
            m = cur_a[s] - g + cur_b[minus_tab[s]];
            if (p > mp) mp = p;
            if (m > mm) mm = m;
        end
        llr = sat(mm - mp);
        ext = EXT_EN ? sat(llr - cur_sys - cur_apr) : 0;
    endtask

    // 0: all zero, 1: alpha1=100/g1=10, 2/3: saturation +/-, 4: random
    task automatic gen_step(input int mode);
        int r;
        for (int s = 0; s < 8; s++) begin
            cur_a[s] = 0;
            cur_b[s] = 0;
        end
        cur_g1 = 0; cur_g2 = 0; cur_sys = 0; cur_apr = 0;
        cur_tag = mode;
        case (mode)
            1: begin cur_a[1] = 100;   cur_g1 = 10; cur_sys = 5; cur_apr = 3; end
            2: begin cur_a[0] = 20000; cur_g1 = -5000; end
            3: begin cur_a[0] = 20000; cur_g1 = 5000;  end
            4: begin
                r = ($urandom_range(0, 7) == 0) ? 8000 : 40;
                for (int s = 0; s < 8; s++) begin
                    cur_a[s] = rnd(r);
                    cur_b[s] = rnd(r);
                end
                cur_g1  = rnd(r / 2);
                cur_g2  = rnd(r / 2);
                cur_sys = rnd(30);
                cur_apr = rnd(30);
            end
            default: ;
        endcase
        for (int s = 0; s < 8; s++) begin
            bus.alpha_in[s*W +: W] = W'(cur_a[s]);
            bus.beta_in[s*W +: W]  = W'(cur_b[s]);
        end
        bus.g1      = W'(cur_g1);
        bus.g2      = W'(cur_g2);
        bus.sys     = W'(cur_sys);
        bus.apriori = W'(cur_apr);
    endtask

    // Called right after a negedge with inputs already driven; samples the
    // handshakes that the coming posedge will act on, then advances a cycle.
    task automatic tick();
        bit   last_now;
        int   o_llr, o_ext;
        exp_t e;
        last_now = 1'b0;
        #1;
        if (!rst) begin
            if (bus.out_valid && !bus.out_ready)
                check("in_ready_stall", int'(bus.in_ready), 0);
            if (acc_cnt == cur_n && bus.busy)
                check("in_ready_drain", int'(bus.in_ready), 0);
            if (bus.out_valid && bus.out_ready) begin
                o_llr = int'($signed(bus.llr_out));
                o_ext = int'($signed(bus.ext_out));
                if (exp_q.size() == 0) begin
                    check("spurious_out", int'(bus.out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    beat_no++;
                    $display("[TB] beat %0d llr=%0d ext=%0d last=%0b (exp %0d/%0d/%0b)",
                             beat_no, o_llr, o_ext, bus.out_last, e.llr, e.ext, e.last);
                    check("llr", o_llr, e.llr);
                    check("ext", o_ext, e.ext);
                    check("last", int'(bus.out_last), int'(e.last));
                    if (chk_lat) check("latency", cyc - e.cyc, LAT);
                    case (e.tag)
                        0: check("llr_zero", o_llr, 0);
                        1: begin
                            check("llr_m20", o_llr, -20);
                            check("ext_dir", o_ext, EXT_EN ? -28 : 0);
                        end
                        2: check("llr_sat_pos", o_llr, 127);
                        3: check("llr_sat_neg", o_llr, -128);
                        default: ;
                    endcase
                    if (e.last) begin
                        check("busy_at_last", int'(bus.busy), 1);
                        last_now = 1'b1;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model(e.llr, e.ext);
                e.last = (acc_cnt == cur_n - 1);
                e.cyc  = cyc;
                e.tag  = cur_tag;
                exp_q.push_back(e);
                acc_cnt++;
                have_step = 1'b0;
            end
        end
        @(negedge clk);
        cyc++;
        if (last_now) check("busy_fall", int'(bus.busy), 0);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_block(input int n, input int mode, input int rdy_mode,
                             input bit gaps, input int abort_at);
        bit done;
        cur_n     = n;
        acc_cnt   = 0;
        have_step = 1'b0;
        chk_lat   = (rdy_mode == 0);
        bus.blklen       = BLK_W'(n);
        bus.blklen_valid = 1'b1;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b1;
        tick();
        bus.blklen_valid = 1'b0;
        check("busy_start", int'(bus.busy), 1);
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (abort_at >= 0 && acc_cnt == abort_at) begin
                rst = 1'b1;
                bus.in_valid = 1'b0;
                tick();
                rst = 1'b0;
                exp_q.delete();
                check("rst_out_valid", int'(bus.out_valid), 0);
                check("rst_busy", int'(bus.busy), 0);
                check("rst_in_ready", int'(bus.in_ready), 0);
                return;
            end
            case (rdy_mode)
                1:       bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
                2:       bus.out_ready = ($urandom_range(0, 1) == 1);
                default: bus.out_ready = 1'b1;
            endcase
            if (!have_step && acc_cnt < n) begin
                gen_step(mode);
                have_step = 1'b1;
            end
            bus.in_valid = have_step && (!gaps || $urandom_range(0, 3) != 0);
            tick();
            done = (acc_cnt == n) && (exp_q.size() == 0) && !bus.busy;
        end
        bus.in_valid = 1'b0;
        check("block_pending", exp_q.size() + int'(bus.busy) + (n - acc_cnt), 0);
    endtask

    initial begin
        bus.blklen       = '0;
        bus.blklen_valid = 1'b0;
        bus.in_valid     = 1'b0;
        bus.alpha_in     = '0;
        bus.beta_in      = '0;
        bus.g1           = '0;
        bus.g2           = '0;
        bus.sys          = '0;
        bus.apriori      = '0;
        bus.out_ready    = 1'b1;
        cur_n = 0; acc_cnt = 0; cyc = 0; beat_no = 0; cur_tag = 0;
        have_step = 1'b0; chk_lat = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid0", int'(bus.out_valid), 0);
        check("rst_in_ready0", int'(bus.in_ready), 0);
        check("rst_busy0", int'(bus.busy), 0);
        check("rst_llr0", int'(bus.llr_out), 0);
        check("rst_ext0", int'(bus.ext_out), 0);
        check("rst_last0", int'(bus.out_last), 0);

        run_block(4, 0, 0, 1'b0, -1);          // zeros, latency, last, busy fall
        run_block(2, 1, 0, 1'b0, -1);          // llr -20 / ext -28
        run_block(2, 2, 0, 1'b0, -1);          // saturate high
        run_block(2, 3, 0, 1'b0, -1);          // saturate low
        run_block(8, 4, 1, 1'b0, -1);          // 1,0,0,1 back-pressure
        run_block(8, 4, 0, 1'b0, 3);           // reset after 3 accepts
        run_block(2, 4, 0, 1'b0, -1);          // recovery block

        bus.blklen       = '0;                 // blklen 0 must be ignored
        bus.blklen_valid = 1'b1;
        tick();
        bus.blklen_valid = 1'b0;
        check("blklen0_busy", int'(bus.busy), 0);
        check("blklen0_in_ready", int'(bus.in_ready), 0);

        for (int b = 0; b < 10; b++) begin
            run_block(int'($urandom_range(1, 20)), 4, int'($urandom_range(0, 2)),
                      1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
